// File: rtl/poly_frommsg_seq.sv
// poly_frommsg_seq: expands a 256-bit message into Kyber coefficients, two per beat.
// Optional build macro ATHOS_FROMMSG_OUTREG_EN adds a 2-entry skid buffer on the pair outputs.
module poly_frommsg_seq #(
    parameter int Q       = 3329,
    parameter int COEFF_W = 16,
    parameter int N       = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               msg_valid_i,
    output logic               msg_ready_o,
    input  logic [31:0]        msg_data_i,
    output logic               coeff_valid_o,
    input  logic               coeff_ready_i,
    output logic [COEFF_W-1:0] coeff0_o,
    output logic [COEFF_W-1:0] coeff1_o,
    output logic [7:0]         coeff_idx_o,
    output logic               busy_o,
    output logic               done_o
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_WORD = 2'd1;
    localparam logic [1:0] EMIT      = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;
    localparam int WORDS = N / 32;
    localparam int WW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(WORDS - 1);
    localparam logic [COEFF_W-1:0] ONE = COEFF_W'((Q + 1) / 2);

    logic [1:0]         state;
    logic [31:0]        sr;
    logic [WW-1:0]      word_cnt;
    logic [3:0]         beat;
    logic [7:0]         idx;
    logic               c_valid;
    logic               c_ready;
    logic               buf_empty;
    logic [COEFF_W-1:0] c0;
    logic [COEFF_W-1:0] c1;
    logic [7:0]         c_idx;

    assign c_valid     = state == EMIT;
    assign c0          = (c_valid && sr[0]) ? ONE : '0;
    assign c1          = (c_valid && sr[1]) ? ONE : '0;
    assign c_idx       = c_valid ? idx : '0;
    assign msg_ready_o = state == WAIT_WORD;
    assign busy_o      = state != IDLE;
    assign done_o      = state == DONE && buf_empty;

    // control FSM: load a word, emit its 16 bit pairs, repeat until the last word drains
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            sr       <= '0;
            word_cnt <= '0;
            beat     <= '0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    state    <= WAIT_WORD;
                    word_cnt <= '0;
                    idx      <= '0;
                end
                WAIT_WORD: if (msg_valid_i) begin
                    sr    <= msg_data_i;
                    beat  <= '0;
                    state <= EMIT;
                end
                EMIT: if (c_ready) begin
                    sr   <= sr >> 2;
                    idx  <= idx + 8'd2;
                    beat <= beat + 4'd1;
                    if (beat == 4'd15) begin
                        if (word_cnt < LAST_WORD) begin
                            word_cnt <= word_cnt + WW'(1);
                            state    <= WAIT_WORD;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: if (buf_empty) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ATHOS_FROMMSG_OUTREG_EN
    localparam int DW = 8 + 2 * COEFF_W;
    logic          m_v;
    logic          s_v;
    logic [DW-1:0] m_d;
    logic [DW-1:0] s_d;

    assign c_ready   = !s_v;
    assign buf_empty = !m_v && !s_v;
    assign coeff_valid_o = m_v;
    assign {coeff_idx_o, coeff1_o, coeff0_o} = m_v ? m_d : '0;

    // main register drives the outputs; the skid entry catches a pair arriving during a stall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
            m_d <= '0;
            s_d <= '0;
        end else if (!m_v || coeff_ready_i) begin
            m_v <= s_v || c_valid;
            m_d <= s_v ? s_d : {c_idx, c1, c0};
            s_v <= 1'b0;
        end else if (c_valid && !s_v) begin
            s_v <= 1'b1;
            s_d <= {c_idx, c1, c0};
        end
    end
`else
    assign c_ready       = coeff_ready_i;
    assign buf_empty     = 1'b1;
    assign coeff_valid_o = c_valid;
    assign coeff0_o      = c0;
    assign coeff1_o      = c1;
    assign coeff_idx_o   = c_idx;
`endif
endmodule

// File: tb/tb_poly_frommsg_seq.sv
// tb_poly_frommsg_seq: directed scenarios against a bit-indexing reference of the message expansion.
module tb_poly_frommsg_seq;
`ifdef ATHOS_FROMMSG_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    logic        clk = 0;
    logic        rst_i = 1;
    logic        start_i = 0;
    logic        msg_valid_i = 0;
    logic        msg_ready_o;
    logic [31:0] msg_data_i = 0;
    logic        coeff_valid_o;
    logic        coeff_ready_i = 0;
    logic [15:0] coeff0_o;
    logic [15:0] coeff1_o;
    logic [7:0]  coeff_idx_o;
    logic        busy_o;
    logic        done_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [255:0] msg;
    logic [15:0]  got [256];
    int exp_idx;
    int pairs;
    int dones;
    bit held;

    poly_frommsg_seq dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
        .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_data_i(msg_data_i),
        .coeff_valid_o(coeff_valid_o), .coeff_ready_i(coeff_ready_i),
        .coeff0_o(coeff0_o), .coeff1_o(coeff1_o), .coeff_idx_o(coeff_idx_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_c(input int i);
        return msg[i] ? 16'd1665 : 16'd0;
    endfunction

    // per-cycle compare against the reference, run at the negedge
    task automatic observe();
        if (coeff_valid_o) begin
            if (exp_idx > 254) begin
                chk("overrun", 64'(exp_idx), 64'd254);
            end else begin
                chk("idx", 64'(coeff_idx_o), 64'(exp_idx));
                chk("coeff0", 64'(coeff0_o), 64'(ref_c(exp_idx)));
                chk("coeff1", 64'(coeff1_o), 64'(ref_c(exp_idx + 1)));
                if (coeff_ready_i) begin
                    got[exp_idx] = coeff0_o;
                    got[exp_idx + 1] = coeff1_o;
                    exp_idx += 2;
                    pairs++;
                    held = 0;
                end else begin
                    held = 1;
                end
            end
        end else begin
            if (held) chk("stall_drop", 64'(coeff_valid_o), 64'd1);
            held = 0;
            chk("idle_zero", 64'({coeff0_o, coeff1_o, coeff_idx_o}), 64'd0);
        end
        if (done_o) dones++;
    endtask

    task automatic run(input logic [255:0] m, input bit rnd, input bit noise,
                       input int abort_at, input bit timing);
        int wp;
        int first_hs;
        int first_v;
        int done_cyc;
        int post;
        bit hs;
        msg = m;
        exp_idx = 0;
        pairs = 0;
        dones = 0;
        held = 0;
        wp = 0;
        first_hs = -1;
        first_v = -1;
        done_cyc = -1;
        post = 0;
        @(posedge clk);
        #1 start_i = 1;
        for (int k = 0; k < 4000 && post < 4; k++) begin
            @(negedge clk);
            if (first_v < 0 && coeff_valid_o) first_v = cyc;
            observe();
            if (done_o && done_cyc < 0) done_cyc = cyc;
            if (done_cyc >= 0) post++;
            hs = msg_valid_i && msg_ready_o;
            if (hs && first_hs < 0) first_hs = cyc;
            @(posedge clk);
            #1;
            if (hs) wp++;
            start_i = noise && coeff_valid_o && $urandom_range(0, 2) == 0;
            msg_valid_i = noise || (wp < 8 && (!rnd || $urandom_range(0, 3) != 0));
            msg_data_i = wp < 8 ? m[32*wp +: 32] : $urandom;
            coeff_ready_i = !rnd || $urandom_range(0, 2) != 0;
            if (abort_at >= 0 && exp_idx >= abort_at) begin
                start_i = 0;
                return;
            end
        end
        start_i = 0;
        msg_valid_i = 0;
        chk("pairs", 64'(pairs), 64'd128);
        chk("done_pulses", 64'(dones), 64'd1);
        if (timing) begin
            chk("first_pair_lat", 64'(first_v - first_hs), 64'(LAT));
            chk("done_lat", 64'(done_cyc - first_hs), 64'(135 + LAT));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, 64'({msg_ready_o, coeff_valid_o, busy_o, done_o, coeff0_o, coeff1_o, coeff_idx_o}), 64'd0);
    endtask

    initial begin
        logic [255:0] m;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1 rst_i = 0;

        run({256{1'b1}}, 0, 0, -1, 1);
        chk("all_ones_c254", 64'(got[254]), 64'd1665);
        chk("all_ones_c0", 64'(got[0]), 64'd1665);

        run(256'h5, 0, 0, -1, 1);
        chk("w5_c0", 64'(got[0]), 64'd1665);
        chk("w5_c1", 64'(got[1]), 64'd0);
        chk("w5_c2", 64'(got[2]), 64'd1665);
        chk("w5_c3", 64'(got[3]), 64'd0);
        chk("w5_c4", 64'(got[4]), 64'd0);

        for (int w = 0; w < 8; w++) m[32*w +: 32] = $urandom;
        run(m, 1, 0, -1, 0);

        for (int w = 0; w < 8; w++) m[32*w +: 32] = $urandom;
        run(m, 0, 1, -1, 1);

        for (int w = 0; w < 8; w++) m[32*w +: 32] = $urandom;
        run(m, 0, 0, 106, 0);
        rst_i = 1;
        @(posedge clk);
        #1 rst_i = 0;
        coeff_ready_i = 1;
        msg_valid_i = 0;
        @(negedge clk);
        check_reset_outputs("abort_outputs");
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        chk("abort_idle", 64'(busy_o), 64'd0);
        run(m, 0, 0, -1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
